// File: rtl/cdec8_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cdec8_mem_arbiter_pkg
// Shared definitions for the CDEC8 memory arbiter:
//   - arb_state_t : arbiter state encoding (3 bits)
//   - WDT_LIMIT   : idle-counter value that forces the host off memory
//                   (used only when CDEC8_ARB_WDT_EN is defined)
// ----------------------------------------------------------------------------
package cdec8_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,  // CPU owns memory
        ST_ENTER   = 3'd1,  // CPU being put into reset, host not yet granted
        ST_HOST    = 3'd2,  // host owns memory, waiting for an access strobe
        ST_WAIT    = 3'd3,  // accepted host access, RAM read data settling
        ST_RELEASE = 3'd4   // memory back on the CPU side, CPU still in reset
    } arb_state_t;

    localparam logic [15:0] WDT_LIMIT = 16'hFFFF;

endpackage

// File: rtl/cdec8_arb_mux.sv
// ----------------------------------------------------------------------------
// cdec8_arb_mux
// Combinational select of the RAM address / write data / write enable,
// keyed by the arbiter state. Three sources: CPU, live host port, and the
// host access captured at acceptance (held through the WAIT cycle).
//
// Ports:
//   state                    in   arbiter state
//   cpu_adrs/cpu_data_out    in   CDEC8 address / write data
//   cpu_mmwr_en              in   CDEC8 write enable
//   host_adrs/host_wdata     in   live host address / write data
//   host_valid/host_we       in   host strobe / write flag
//   held_adrs/held_wdata     in   captured host access
//   mem_adrs/mem_wdata       out  RAM address / write data
//   mem_we                   out  RAM write enable
// ----------------------------------------------------------------------------
module cdec8_arb_mux
    import cdec8_mem_arbiter_pkg::*;
(
    input  arb_state_t  state,
    input  logic [7:0]  cpu_adrs,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_mmwr_en,
    input  logic [7:0]  host_adrs,
    input  logic [7:0]  host_wdata,
    input  logic        host_valid,
    input  logic        host_we,
    input  logic [7:0]  held_adrs,
    input  logic [7:0]  held_wdata,
    output logic [7:0]  mem_adrs,
    output logic [7:0]  mem_wdata,
    output logic        mem_we
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        mem_adrs  = cpu_adrs;
        mem_wdata = cpu_data_out;
        mem_we    = 1'b0;
        case (state)
            ST_RUN: begin
                mem_we = cpu_mmwr_en;
            end
            ST_HOST: begin
                mem_adrs  = host_adrs;
                mem_wdata = host_wdata;
                mem_we    = host_valid & host_we;
            end
            ST_WAIT: begin
                // Address stays on the accepted access; the write already
                // happened on the acceptance edge, so the enable stays low.
                mem_adrs  = held_adrs;
                mem_wdata = held_wdata;
            end
            default: begin
                // ENTER / RELEASE: CPU side on the bus, writes blocked.
            end
        endcase
    end

endmodule

// File: rtl/cdec8_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cdec8_mem_arbiter
// Shares the CDEC8 8-bit memory port between the CPU and a host/loader port.
// While the host owns memory the CPU is held in reset, so it never observes
// a partial access. RAM is synchronous: write on the mem_we edge, read data
// one cycle after the address.
//
// Parameters:
//   RST_CYCLES  cycles cpu_reset_N stays low after the host releases (1..15)
//   BOOT_HOLD   1: hold the CPU after reset and hand memory to the host first
//
// Optional feature (macro CDEC8_ARB_WDT_EN):
//   16-bit idle watchdog in HOST; on expiry memory is forced back to the CPU,
//   sticky output wdt_trip is set, and host_req must drop before a new grant.
//
// Ports:
//   clock, reset_N           system clock, async active-low reset
//   cpu_adrs/cpu_data_out/cpu_mmwr_en   CDEC8 memory outputs
//   cpu_data_in              to CDEC8 data_in (= mem_rdata)
//   cpu_reset_N              registered reset to CDEC8
//   host_req/host_gnt        host ownership request / grant
//   host_valid/host_we/host_adrs/host_wdata   host access strobe and payload
//   host_ready/host_rdata    access-complete pulse / read data
//   mem_adrs/mem_wdata/mem_we/mem_rdata       RAM port
//   wdt_trip                 sticky watchdog flag (CDEC8_ARB_WDT_EN only)
// ----------------------------------------------------------------------------
module cdec8_mem_arbiter
    import cdec8_mem_arbiter_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter bit BOOT_HOLD  = 1'b0
) (
    input  logic        clock,
    input  logic        reset_N,
    input  logic [7:0]  cpu_adrs,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_mmwr_en,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_reset_N,
    input  logic        host_req,
    output logic        host_gnt,
    input  logic        host_valid,
    input  logic        host_we,
    input  logic [7:0]  host_adrs,
    input  logic [7:0]  host_wdata,
    output logic        host_ready,
    output logic [7:0]  host_rdata,
    output logic [7:0]  mem_adrs,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
`ifdef CDEC8_ARB_WDT_EN
    ,
    output logic        wdt_trip
`endif
);

    localparam arb_state_t RESET_STATE = BOOT_HOLD ? ST_ENTER : ST_RUN;
    localparam logic [3:0] RST_LAST    = 4'(RST_CYCLES - 1);

    arb_state_t  state;
    logic [3:0]  rel_cnt;
    logic [7:0]  held_adrs;
    logic [7:0]  held_wdata;
    logic        held_we;
    logic        enter_ok;

`ifdef CDEC8_ARB_WDT_EN
    localparam logic [15:0] WDT_TRIP_AT = WDT_LIMIT - 16'd1;
    logic [15:0] wdt_cnt;
    logic        wdt_block;  // set by a trip, cleared once host_req drops

    assign enter_ok = host_req & ~wdt_block;
`else
    assign enter_ok = host_req;
`endif

    // The CPU reads RAM directly; while it is held in reset this is harmless.
    assign cpu_data_in = mem_rdata;

    cdec8_arb_mux u_mux (
        .state        (state),
        .cpu_adrs     (cpu_adrs),
        .cpu_data_out (cpu_data_out),
        .cpu_mmwr_en  (cpu_mmwr_en),
        .host_adrs    (host_adrs),
        .host_wdata   (host_wdata),
        .host_valid   (host_valid),
        .host_we      (host_we),
        .held_adrs    (held_adrs),
        .held_wdata   (held_wdata),
        .mem_adrs     (mem_adrs),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we)
    );

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state       <= RESET_STATE;
            cpu_reset_N <= 1'b0;
            host_gnt    <= 1'b0;
            host_ready  <= 1'b0;
            host_rdata  <= 8'h00;
            rel_cnt     <= 4'd0;
            held_adrs   <= 8'h00;
            held_wdata  <= 8'h00;
            held_we     <= 1'b0;
`ifdef CDEC8_ARB_WDT_EN
            wdt_cnt     <= 16'd0;
            wdt_trip    <= 1'b0;
            wdt_block   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge values of all state registers.
            host_ready <= 1'b0;
`ifdef CDEC8_ARB_WDT_EN
            if (!host_req) wdt_block <= 1'b0;
`endif
            case (state)
                ST_RUN: begin
                    if (enter_ok) begin
                        state       <= ST_ENTER;
                        cpu_reset_N <= 1'b0;
                    end else begin
                        cpu_reset_N <= 1'b1;
                    end
                end

                ST_ENTER: begin
                    cpu_reset_N <= 1'b0;
                    host_gnt    <= 1'b1;
                    state       <= ST_HOST;
`ifdef CDEC8_ARB_WDT_EN
                    wdt_cnt     <= 16'd0;
                    wdt_trip    <= 1'b0;
`endif
                end

                ST_HOST: begin
                    if (host_valid) begin
                        state      <= ST_WAIT;
                        held_adrs  <= host_adrs;
                        held_wdata <= host_wdata;
                        held_we    <= host_we;
`ifdef CDEC8_ARB_WDT_EN
                        wdt_cnt    <= 16'd0;
                    end else if (wdt_cnt == WDT_TRIP_AT) begin
                        // Counter reaches WDT_LIMIT on this edge: evict host.
                        state      <= ST_RELEASE;
                        host_gnt   <= 1'b0;
                        rel_cnt    <= 4'd0;
                        wdt_cnt    <= WDT_LIMIT;
                        wdt_trip   <= 1'b1;
                        wdt_block  <= 1'b1;
`endif
                    end else if (!host_req) begin
                        state      <= ST_RELEASE;
                        host_gnt   <= 1'b0;
                        rel_cnt    <= 4'd0;
                    end
`ifdef CDEC8_ARB_WDT_EN
                    else begin
                        wdt_cnt    <= wdt_cnt + 16'd1;
                    end
`endif
                end

                ST_WAIT: begin
                    // Read data is on mem_rdata now (address was presented
                    // in the acceptance cycle); completion pulses regardless
                    // of host_req so an in-flight access is never dropped.
                    host_ready <= 1'b1;
                    if (!held_we) host_rdata <= mem_rdata;
                    if (!host_req) begin
                        state    <= ST_RELEASE;
                        host_gnt <= 1'b0;
                        rel_cnt  <= 4'd0;
                    end else begin
                        state    <= ST_HOST;
                    end
                end

                ST_RELEASE: begin
                    if (enter_ok) begin
                        state   <= ST_ENTER;
                        rel_cnt <= 4'd0;
                    end else if (rel_cnt == RST_LAST) begin
                        state       <= ST_RUN;
                        cpu_reset_N <= 1'b1;
                        rel_cnt     <= 4'd0;
                    end else begin
                        rel_cnt <= rel_cnt + 4'd1;
                    end
                end

                default: begin
                    // Unreachable encodings: park safely with the CPU held.
                    state       <= ST_ENTER;
                    cpu_reset_N <= 1'b0;
                    host_gnt    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdec8_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdec8_mem_arbiter
// Two arbiter instances share clock/reset/CPU inputs:
//   u0 : BOOT_HOLD=0, full host traffic against a small synchronous RAM model
//   u1 : BOOT_HOLD=1, boot-hold and RELEASE->ENTER re-request sequence
// RUN-state pass-through is table driven; multi-cycle sequences are written
// out cycle by cycle. Watchdog sequence is compiled only with CDEC8_ARB_WDT_EN.
// ----------------------------------------------------------------------------
module tb_cdec8_mem_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_N;
    logic [7:0] cpu_adrs, cpu_data_out;
    logic       cpu_mmwr_en;
    logic       host_req, host_valid, host_we;
    logic [7:0] host_adrs, host_wdata;

    logic [7:0] cpu_data_in0, host_rdata0, mem_adrs0, mem_wdata0, mem_rdata0;
    logic       cpu_reset_N0, host_gnt0, host_ready0, mem_we0;

    logic       host_req1, host_valid1;
    logic [7:0] cpu_data_in1, host_rdata1, mem_adrs1, mem_wdata1;
    logic [7:0] mem_rdata1;
    logic       cpu_reset_N1, host_gnt1, host_ready1, mem_we1;

`ifdef CDEC8_ARB_WDT_EN
    logic       wdt_trip0, wdt_trip1;
`endif

    cdec8_mem_arbiter #(.RST_CYCLES(2), .BOOT_HOLD(1'b0)) u0 (
        .clock(clock), .reset_N(reset_N),
        .cpu_adrs(cpu_adrs), .cpu_data_out(cpu_data_out), .cpu_mmwr_en(cpu_mmwr_en),
        .cpu_data_in(cpu_data_in0), .cpu_reset_N(cpu_reset_N0),
        .host_req(host_req), .host_gnt(host_gnt0),
        .host_valid(host_valid), .host_we(host_we),
        .host_adrs(host_adrs), .host_wdata(host_wdata),
        .host_ready(host_ready0), .host_rdata(host_rdata0),
        .mem_adrs(mem_adrs0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
        .mem_rdata(mem_rdata0)
`ifdef CDEC8_ARB_WDT_EN
        , .wdt_trip(wdt_trip0)
`endif
    );

    cdec8_mem_arbiter #(.RST_CYCLES(2), .BOOT_HOLD(1'b1)) u1 (
        .clock(clock), .reset_N(reset_N),
        .cpu_adrs(cpu_adrs), .cpu_data_out(cpu_data_out), .cpu_mmwr_en(cpu_mmwr_en),
        .cpu_data_in(cpu_data_in1), .cpu_reset_N(cpu_reset_N1),
        .host_req(host_req1), .host_gnt(host_gnt1),
        .host_valid(host_valid1), .host_we(host_we),
        .host_adrs(host_adrs), .host_wdata(host_wdata),
        .host_ready(host_ready1), .host_rdata(host_rdata1),
        .mem_adrs(mem_adrs1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1)
`ifdef CDEC8_ARB_WDT_EN
        , .wdt_trip(wdt_trip1)
`endif
    );

    // Synchronous RAM behind u0: write on the edge, read data one cycle later.
    logic [7:0] ram [256];
    always @(posedge clock) begin
        if (mem_we0) ram[mem_adrs0] <= mem_wdata0;
        mem_rdata0 <= ram[mem_adrs0];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [7:0] adrs;
        logic [7:0] dout;
        logic       we;
        logic [7:0] exp_adrs;
        logic [7:0] exp_wdata;
        logic       exp_we;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;

        vecs[0] = '{8'h10, 8'h33, 1'b0, 8'h10, 8'h33, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b0};
        vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'hA5, 8'h5A, 1'b1};

        reset_N      = 1'b0;
        cpu_adrs     = 8'h00;
        cpu_data_out = 8'h00;
        cpu_mmwr_en  = 1'b0;
        host_req     = 1'b0;
        host_valid   = 1'b0;
        host_we      = 1'b0;
        host_adrs    = 8'h00;
        host_wdata   = 8'h00;
        host_req1    = 1'b1;
        host_valid1  = 1'b0;
        mem_rdata1   = 8'h00;

        // Reset state
        #12;
        check("rst_cpu_reset_N", cpu_reset_N0, 1'b0);
        check("rst_host_gnt",    host_gnt0,    1'b0);
        check("rst_host_ready",  host_ready0,  1'b0);
        check("rst_host_rdata",  host_rdata0,  8'h00);
        check("rst_u1_cpu_reset_N", cpu_reset_N1, 1'b0);
        check("rst_u1_host_gnt",    host_gnt1,    1'b0);

        @(negedge clock);
        reset_N = 1'b1;
        tick();
        check("run_cpu_reset_N_released", cpu_reset_N0, 1'b1);
        check("boot_hold_cpu_held",       cpu_reset_N1, 1'b0);
        check("boot_hold_granted",        host_gnt1,    1'b1);

        // RUN pass-through table
        for (int i = 0; i < 4; i++) begin
            cpu_adrs     = vecs[i].adrs;
            cpu_data_out = vecs[i].dout;
            cpu_mmwr_en  = vecs[i].we;
            #1;
            check($sformatf("run_mem_adrs[%0d]", i),  mem_adrs0,  vecs[i].exp_adrs);
            check($sformatf("run_mem_wdata[%0d]", i), mem_wdata0, vecs[i].exp_wdata);
            check($sformatf("run_mem_we[%0d]", i),    mem_we0,    vecs[i].exp_we);
            tick();
        end

        // host_req with host_valid in the same RUN cycle: valid ignored
        cpu_adrs    = 8'h77;
        cpu_mmwr_en = 1'b1;
        host_req    = 1'b1;
        host_valid  = 1'b1;
        host_we     = 1'b1;
        host_adrs   = 8'h50;
        host_wdata  = 8'hEE;
        #1;
        check("run_ignores_host_adrs", mem_adrs0, 8'h77);
        check("run_ignores_host_we",   mem_we0,   1'b1);
        tick();  // ENTER
        check("enter_cpu_reset_N", cpu_reset_N0, 1'b0);
        check("enter_no_gnt",      host_gnt0,    1'b0);
        check("enter_mem_we_low",  mem_we0,      1'b0);
        host_valid = 1'b0;
        tick();  // HOST
        check("host_gnt",          host_gnt0,    1'b1);
        check("host_cpu_held",     cpu_reset_N0, 1'b0);
        check("host_no_stray_ready", host_ready0, 1'b0);

        // Host write 0x20 <- 0xA5
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_adrs  = 8'h20;
        host_wdata = 8'hA5;
        #1;
        check("wr_mem_we",    mem_we0,    1'b1);
        check("wr_mem_adrs",  mem_adrs0,  8'h20);
        check("wr_mem_wdata", mem_wdata0, 8'hA5);
        tick();  // WAIT
        host_valid = 1'b0;
        host_adrs  = 8'h33;
        #1;
        check("wait_mem_we_low",   mem_we0,     1'b0);
        check("wait_adrs_held",    mem_adrs0,   8'h20);
        check("wait_ready_low",    host_ready0, 1'b0);
        tick();  // HOST, ready pulse
        check("wr_host_ready", host_ready0, 1'b1);

        // Host read of 0x20
        host_valid = 1'b1;
        host_we    = 1'b0;
        host_adrs  = 8'h20;
        #1;
        check("rd_mem_we_low", mem_we0, 1'b0);
        tick();  // WAIT
        host_valid = 1'b0;
        check("ready_one_cycle", host_ready0, 1'b0);
        check("rd_wait_mem_we_low", mem_we0, 1'b0);
        tick();  // HOST, ready
        check("rd_host_ready", host_ready0,  1'b1);
        check("rd_host_rdata", host_rdata0,  8'hA5);
        check("cpu_data_in_follows_ram", cpu_data_in0, 8'hA5);

        // Write 0x30 <- 0x5A, then drop host_req during WAIT
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_adrs  = 8'h30;
        host_wdata = 8'h5A;
        tick();  // WAIT
        host_valid = 1'b0;
        host_req   = 1'b0;
        cpu_adrs   = 8'h60;
        tick();  // RELEASE (1st)
        check("drop_in_wait_ready", host_ready0,  1'b1);
        check("release_gnt_low",    host_gnt0,    1'b0);
        check("release_cpu_held_1", cpu_reset_N0, 1'b0);
        check("release_mem_adrs",   mem_adrs0,    8'h60);
        check("release_mem_we_low", mem_we0,      1'b0);
        tick();  // RELEASE (2nd)
        check("release_cpu_held_2", cpu_reset_N0, 1'b0);
        check("release_ready_low",  host_ready0,  1'b0);
        tick();  // RUN
        check("run_again_cpu_reset_N", cpu_reset_N0, 1'b1);
        check("run_again_mem_we",      mem_we0,      1'b1);
        check("run_again_mem_adrs",    mem_adrs0,    8'h60);
        cpu_mmwr_en = 1'b0;
        cpu_adrs    = 8'h30;
        tick();
        check("host_write_landed", cpu_data_in0, 8'h5A);

        // Reset in the middle of a host access
        host_req = 1'b1;
        tick();  // ENTER
        tick();  // HOST
        host_valid = 1'b1;
        host_we    = 1'b0;
        host_adrs  = 8'h20;
        tick();  // WAIT
        host_valid = 1'b0;
        host_req   = 1'b0;
        reset_N    = 1'b0;
        #1;
        check("midrst_gnt",         host_gnt0,    1'b0);
        check("midrst_cpu_reset_N", cpu_reset_N0, 1'b0);
        check("midrst_mem_we",      mem_we0,      1'b0);
        check("midrst_u1_gnt",      host_gnt1,    1'b0);
        @(negedge clock);
        reset_N = 1'b1;
        tick();
        check("midrst_ready_lost",   host_ready0,  1'b0);
        check("midrst_cpu_runs",     cpu_reset_N0, 1'b1);
        check("boot2_u1_gnt",        host_gnt1,    1'b1);
        check("boot2_u1_cpu_held",   cpu_reset_N1, 1'b0);

        // BOOT_HOLD instance: release, re-request during RELEASE, release again
        host_req1 = 1'b0;
        tick();  // RELEASE
        check("u1_release_gnt",  host_gnt1,    1'b0);
        check("u1_release_held", cpu_reset_N1, 1'b0);
        host_req1 = 1'b1;
        tick();  // ENTER
        check("u1_rereq_gnt_low", host_gnt1,    1'b0);
        check("u1_rereq_held",    cpu_reset_N1, 1'b0);
        tick();  // HOST
        check("u1_regrant",       host_gnt1,    1'b1);
        host_req1 = 1'b0;
        tick();  // RELEASE 1
        check("u1_final_held_1",  cpu_reset_N1, 1'b0);
        tick();  // RELEASE 2
        check("u1_final_held_2",  cpu_reset_N1, 1'b0);
        tick();  // RUN
        check("u1_cpu_runs",      cpu_reset_N1, 1'b1);

`ifdef CDEC8_ARB_WDT_EN
        // Watchdog: grant, then stay idle until forced off memory
        host_req = 1'b1;
        n = 0;
        while (!host_gnt0 && n < 10) begin
            tick();
            n++;
        end
        check("wdt_grant",        host_gnt0, 1'b1);
        check("wdt_trip_initial", wdt_trip0, 1'b0);
        n = 0;
        while (host_gnt0 && n < 70000) begin
            tick();
            n++;
        end
        check("wdt_idle_cycles", n,         65535);
        check("wdt_trip_set",    wdt_trip0, 1'b1);
        repeat (5) tick();
        check("wdt_no_regrant",  host_gnt0,    1'b0);
        check("wdt_cpu_runs",    cpu_reset_N0, 1'b1);
        check("wdt_trip_sticky", wdt_trip0,    1'b1);
        host_req = 1'b0;
        tick();
        host_req = 1'b1;
        tick();  // ENTER
        tick();  // HOST
        check("wdt_trip_cleared", wdt_trip0, 1'b0);
        check("wdt_regrant",      host_gnt0, 1'b1);
        host_req = 1'b0;
        repeat (4) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdec8_mem_arbiter.md
Name: cdec8_mem_arbiter

Overview:
Shares the CDEC8 core's 8-bit memory port between the CPU and a host/loader port (program download, memory inspection).
- While the host owns memory, the arbiter holds the CPU in reset, so the CPU never sees a partial access.
- Sits between CDEC8 and the program/data RAM. Drives the CPU's reset_N and muxes adrs/data/write-enable.
- RAM is synchronous: write in the cycle `mem_we` is high; read data valid one cycle after the address.

Parameters:
- RST_CYCLES, 2: cycles `cpu_reset_N` stays low after the host releases memory (1..15).
- BOOT_HOLD, 0: 1 = after reset, hold the CPU and wait for the host (loader boot); 0 = CPU runs after reset.

Ports:
- `clock`  in  1  system clock.
- `reset_N`  in  1  asynchronous active-low reset.
- `cpu_adrs`  in  8  CDEC8 adrs.
- `cpu_data_out`  in  8  CDEC8 data_out.
- `cpu_mmwr_en`  in  1  CDEC8 mmwr_en.
- `cpu_data_in`  out  8  to CDEC8 data_in; equals `mem_rdata`.
- `cpu_reset_N`  out  1  to CDEC8 reset_N; registered.
- `host_req`  in  1  level request for memory ownership.
- `host_gnt`  out  1  host owns memory.
- `host_valid`  in  1  one-cycle access strobe, sampled only when accepted.
- `host_we`  in  1  1 = write, 0 = read.
- `host_adrs`  in  8  host address.
- `host_wdata`  in  8  host write data.
- `host_ready`  out  1  one-cycle access-complete pulse.
- `host_rdata`  out  8  read data, valid with `host_ready`.
- `mem_adrs`  out  8  RAM address.
- `mem_wdata`  out  8  RAM write data.
- `mem_we`  out  1  RAM write enable.
- `mem_rdata`  in  8  RAM read data.

Behaviour:
- One clock, `clock`. Reset `reset_N` is asynchronous, active-low.
- Reset values:
  - state = BOOT_HOLD ? ENTER : RUN.
  - `cpu_reset_N` = 0; `host_gnt` = 0; `host_ready` = 0; `host_rdata` = 0; release counter = 0.
- States and transitions:
  - RUN: CPU owns memory.
    - `mem_adrs` = `cpu_adrs`, `mem_wdata` = `cpu_data_out`, `mem_we` = `cpu_mmwr_en`.
    - `cpu_reset_N` goes to 1 on the first clock after reset deassertion.
    - `host_req` = 1 → ENTER.
  - ENTER: `cpu_reset_N` <= 0; `mem_we` = 0. Next cycle → HOST, with `host_gnt` <= 1.
  - HOST: mux selects host; `mem_we` = `host_valid & host_we`.
    - `host_valid` = 1 → WAIT (access accepted).
    - Else if `host_req` = 0 → RELEASE, with `host_gnt` <= 0.
  - WAIT (exactly 1 cycle): `mem_we` = 0; `mem_adrs` holds the accepted address.
    - `host_ready` <= 1 next cycle; `host_rdata` <= `mem_rdata` for reads (unchanged for writes).
    - Then → HOST, or → RELEASE if `host_req` = 0.
    - `host_valid` is ignored in WAIT.
  - RELEASE: mux back to CPU with `mem_we` forced 0; `cpu_reset_N` held 0 for RST_CYCLES cycles via counter, then → RUN with `cpu_reset_N` <= 1.
    - `host_req` reasserted during RELEASE → ENTER (counter cleared).
- Timing: host access throughput is max 1 per 2 cycles; latency from accepted valid to `host_ready` is 2 cycles.
- Boundary conditions:
  - `host_req` dropped with an access in WAIT: the access completes and `host_ready` still pulses.
  - `host_req` and `host_valid` in the same RUN cycle: valid is ignored (no grant yet).
  - Reset mid-access: all outputs return to reset values immediately; the pending `host_ready` is lost.
  - Address wrap-around: none; addresses pass through unmodified.
- `mem_we` never asserts in ENTER, WAIT or RELEASE.
- `cpu_data_in` = `mem_rdata` at all times; harmless while the CPU is held.

Optional Feature:
CDEC8_ARB_WDT_EN
- Enabled:
  - Adds a 16-bit idle counter in HOST, cleared by `host_valid`.
  - Reaching 16'hFFFF forces → RELEASE regardless of `host_req`, and sets the sticky output `wdt_trip` (1 bit, reset 0). `wdt_trip` clears on the next ENTER.
  - After a trip, `host_req` must go low before a new ENTER.
- Disabled: no counter and no `wdt_trip` port; the host may hold memory indefinitely.

Decomposition:
- Shared package/header (`my_const.vh`): state encodings ST_RUN, ST_ENTER, ST_HOST, ST_WAIT, ST_RELEASE (3-bit); the WDT limit constant.
- One natural sub-module: cdec8_arb_mux, the combinational 3-way select of adrs/wdata/we keyed by state. Everything else stays in the top.

Test Plan:
1. Reset with BOOT_HOLD=0, no host_req → `cpu_reset_N` = 1 one cycle after reset release; `mem_adrs` follows `cpu_adrs` (e.g. 8'h10); `mem_we` = `cpu_mmwr_en`.
2. host_req=1 in RUN → `cpu_reset_N` = 0 next cycle, `host_gnt` = 1 the cycle after. Then write adrs 8'h20, data 8'hA5 → `mem_we` high one cycle, `host_ready` pulses 2 cycles after valid.
3. Host read of 8'h20 after the write → `host_ready` with `host_rdata` = 8'hA5; `mem_we` = 0 throughout.
4. Drop host_req in the WAIT cycle → `host_ready` still pulses; `cpu_reset_N` stays low exactly RST_CYCLES=2 cycles after RELEASE entry, then 1; `mem_adrs` tracks `cpu_adrs`.
5. BOOT_HOLD=1 → `cpu_reset_N` stays 0 after reset until a full host grant/release cycle completes; reassert host_req during RELEASE → returns to ENTER, CPU stays held.
6. With CDEC8_ARB_WDT_EN: grant, then 65535 idle cycles → forced RELEASE, `wdt_trip` = 1, no re-grant while host_req stays high.
